// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg
// Shared constants for the interrupt controller: register offsets relative
// to BASE, the source index of each interrupt line, and the FSM state type.
package irq_controller_pkg;

   // Register byte offsets from BASE.
   localparam logic [31:0] OFF_IMASK  = 32'h0000_0000;
   localparam logic [31:0] OFF_IPEND  = 32'h0000_0004;
   localparam logic [31:0] OFF_ICAUSE = 32'h0000_0008;

   // Source indices; a lower index has higher priority.
   localparam logic [1:0] SRC_TIMER   = 2'd0;
   localparam logic [1:0] SRC_UART_RX = 2'd1;
   localparam logic [1:0] SRC_UART_TX = 2'd2;
   localparam logic [1:0] SRC_EXT     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

endpackage : irq_controller_pkg

// File: rtl/irq_prio_enc.sv
// irq_prio_enc
// 4-to-2 fixed-priority encoder; bit 0 has the highest priority.
// Ports:
//   req   in  4  request vector
//   valid out 1  at least one request bit set
//   idx   out 2  index of the highest-priority set bit (0 when none)
module irq_prio_enc
   import irq_controller_pkg::*;
(
   input  logic [3:0] req,
   output logic       valid,
   output logic [1:0] idx
);

   // NOTE: every output of a combinational block gets a default first so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      valid = |req;
      idx   = SRC_TIMER;
      if (req[0])      idx = SRC_TIMER;
      else if (req[1]) idx = SRC_UART_RX;
      else if (req[2]) idx = SRC_UART_TX;
      else if (req[3]) idx = SRC_EXT;
   end

endmodule : irq_prio_enc

// File: rtl/irq_controller.sv
// irq_controller
// Four-source interrupt controller with memory-mapped mask/pending/cause
// registers and a three-state request FSM that only interrupts user mode.
// Ports:
//   clk        in  1   system clock, rising edge
//   reset      in  1   synchronous active-high reset
//   src_pulse  in  4   one-cycle request pulses (timer, uart_rx, uart_tx, ext)
//   pc_super   in  1   1 while executing in supervisor mode
//   addr       in  32  bus byte address
//   wdata      in  32  bus write data
//   mem_rd     in  1   bus read strobe
//   mem_wr     in  1   bus write strobe
//   rdata      out 32  combinational read data
//   irq        out 1   registered interrupt request
//   irq_id     out 2   registered index of the current/last interrupt
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int          NSRC = 4,
   parameter logic [31:0] BASE = 32'h4000_0030
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src_pulse,
   input  logic            pc_super,
   input  logic [31:0]     addr,
   input  logic [31:0]     wdata,
   input  logic            mem_rd,
   input  logic            mem_wr,
   output logic [31:0]     rdata,
   output logic            irq,
   output logic [1:0]      irq_id
);

   logic [NSRC-1:0] imask_q, imask_d;
   logic [NSRC-1:0] ipend_q, ipend_d;
   logic [1:0]      irq_id_q, irq_id_d;
   logic            irq_q, irq_d;
   irq_state_e      state_q, state_d;

   logic            hit_imask, hit_ipend, hit_icause;
   logic [NSRC-1:0] active;
   logic            act_valid;
   logic [1:0]      act_idx;

   // Only the low NSRC bits of a write carry register content.
   logic unused_wdata;
   assign unused_wdata = ^{wdata[31:NSRC], 1'b0};

   assign hit_imask  = (addr == BASE + OFF_IMASK);
   assign hit_ipend  = (addr == BASE + OFF_IPEND);
   assign hit_icause = (addr == BASE + OFF_ICAUSE);

   // The FSM works from registered state, so a mask/pending change is seen
   // one edge after the bus write that made it.
   assign active = ipend_q & imask_q;

   irq_prio_enc u_prio_enc (
      .req   (active),
      .valid (act_valid),
      .idx   (act_idx)
   );

   // Register file next-state.
   always_comb begin
      imask_d = imask_q;
      ipend_d = ipend_q;
      if (mem_wr && hit_imask) imask_d = wdata[NSRC-1:0];
      if (mem_wr && hit_ipend) ipend_d = ipend_d & ~wdata[NSRC-1:0];
      // Set is applied after the clear so a new pulse beats a W1C.
      ipend_d = ipend_d | src_pulse;
   end

   // Request FSM next-state; irq and irq_id are registered outputs.
   always_comb begin
      state_d  = state_q;
      irq_d    = irq_q;
      irq_id_d = irq_id_q;
      unique case (state_q)
         ST_IDLE: begin
            irq_d = 1'b0;
            if (act_valid && !pc_super) begin
               state_d  = ST_ASSERT;
               irq_d    = 1'b1;
               irq_id_d = act_idx;
            end
         end
         ST_ASSERT: begin
            if (pc_super) begin
               // CPU took the interrupt; no nesting until it leaves kernel.
               state_d = ST_SERVICE;
               irq_d   = 1'b0;
            end else if (!act_valid) begin
               state_d = ST_IDLE;
               irq_d   = 1'b0;
            end else begin
               irq_d = 1'b1;
            end
         end
         ST_SERVICE: begin
            irq_d = 1'b0;
            if (!pc_super) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            irq_d   = 1'b0;
         end
      endcase
   end

   // Read mux; anything but a strobed, mapped read returns zero.
   always_comb begin
      rdata = 32'h0;
      if (mem_rd) begin
         if (hit_imask)       rdata = {{(32-NSRC){1'b0}}, imask_q};
         else if (hit_ipend)  rdata = {{(32-NSRC){1'b0}}, ipend_q};
         else if (hit_icause) rdata = {30'b0, irq_id_q};
      end
   end

   // NOTE: reset is synchronous, so it lives inside the clocked branch and
   // overrides any pulse or bus write arriving on the same edge.
   // NOTE: state flops use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         imask_q  <= '0;
         ipend_q  <= '0;
         irq_id_q <= 2'd0;
         irq_q    <= 1'b0;
         state_q  <= ST_IDLE;
      end else begin
         imask_q  <= imask_d;
         ipend_q  <= ipend_d;
         irq_id_q <= irq_id_d;
         irq_q    <= irq_d;
         state_q  <= state_d;
      end
   end

   assign irq    = irq_q;
   assign irq_id = irq_id_q;

endmodule : irq_controller
